// File: rtl/float_pipe_result_collector_pkg.sv
// Shared FPU definitions: single-precision width, per-core pipeline latencies
// and a width helper used to size pointers and counters.
package float_pipe_result_collector_pkg;

  localparam int FPU_SP_WIDTH = 32;
  localparam int FMUL_LATENCY = 5;
  localparam int FADD_LATENCY = 7;

  // Bits needed to hold values 0..value-1; never returns less than 1 so a
  // single-entry structure still gets a legal vector.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    if (result < 32'sd1) begin
      return 32'sd1;
    end else begin
      return result;
    end
  endfunction

endpackage

// File: rtl/float_pipe_result_collector_chk.sv
// Protocol checks on the result FIFO: the credit scheme must guarantee that a
// capture never meets a full FIFO and a pop never meets an empty one.
module fpu_result_fifo_chk
  import float_pipe_result_collector_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input logic             clock,
  input logic             reset_n,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] count
);

  no_push_when_full: assert property (
    @(posedge clock) disable iff (!reset_n) push |-> (count != CNT_W'(DEPTH))
  );

  no_pop_when_empty: assert property (
    @(posedge clock) disable iff (!reset_n) pop |-> (count != {CNT_W{1'b0}})
  );

endmodule

// File: rtl/float_pipe_result_collector_fifo.sv
// Result FIFO with modulo-DEPTH pointers (any DEPTH) and simultaneous
// push/pop; the head reads as zero while the FIFO is empty.
module fpu_result_fifo
  import float_pipe_result_collector_pkg::*;
#(
  parameter int WIDTH = FPU_SP_WIDTH,
  parameter int DEPTH = 8,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign head  = (count_r != {CNT_W{1'b0}}) ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};

  fpu_result_fifo_chk #(.DEPTH(DEPTH)) u_chk (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .count   (count_r)
  );

endmodule

// File: rtl/float_pipe_result_collector.sv
// Return path for an enable-less fixed-latency FPU core: a valid shift register
// follows each issue through the core, and issue credit is granted only while
// a FIFO slot is reserved for every result already in flight.
module float_pipe_result_collector
  import float_pipe_result_collector_pkg::*;
#(
  parameter int WIDTH   = FPU_SP_WIDTH,
  parameter int LATENCY = FMUL_LATENCY,
  parameter int DEPTH   = 8,
  localparam int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [WIDTH-1:0] pipe_result,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_data,
  output logic [CNT_W-1:0] occupancy
);

  logic [LATENCY-1:0] vsr_r;
  logic [CNT_W-1:0]   credits_r;
  logic [CNT_W-1:0]   fifo_count_s;
  logic               issue_accept_s;
  logic               capture_s;
  logic               dequeue_s;

  assign issue_ready    = (credits_r != {CNT_W{1'b0}});
  assign issue_accept_s = issue_valid && issue_ready;
  assign capture_s      = vsr_r[LATENCY-1];
  assign deq_valid      = (fifo_count_s != {CNT_W{1'b0}});
  assign dequeue_s      = deq_valid && deq_ready;
  assign occupancy      = CNT_W'(DEPTH) - credits_r;

  // The core cannot stall, so the valid bits advance every cycle; clearing
  // them on reset abandons results still inside the core.
  generate
    if (LATENCY == 1) begin : g_vsr_single
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          vsr_r <= 1'b0;
        end else begin
          vsr_r <= issue_accept_s;
        end
      end
    end else begin : g_vsr_multi
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          vsr_r <= {LATENCY{1'b0}};
        end else begin
          vsr_r <= {vsr_r[LATENCY-2:0], issue_accept_s};
        end
      end
    end
  endgenerate

  // Credits are consumed at issue, not at capture, so in-flight results hold their slot.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      credits_r <= CNT_W'(DEPTH);
    end else begin
      case ({issue_accept_s, dequeue_s})
        2'b10:   credits_r <= credits_r - CNT_W'(1);
        2'b01:   credits_r <= credits_r + CNT_W'(1);
        default: credits_r <= credits_r;
      endcase
    end
  end

  fpu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (capture_s),
    .push_data (pipe_result),
    .pop       (dequeue_s),
    .head      (deq_data),
    .count     (fifo_count_s)
  );

endmodule

// File: tb/tb_float_pipe_result_collector.sv
// Directed bench: a behavioural 5-stage core feeds two collectors (DEPTH 8 and
// DEPTH 3); expected values are hand-derived from issue timing.
module tb_float_pipe_result_collector;

  localparam int LAT = 5;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        issue_valid, issue_ready, deq_valid, deq_ready;
  logic        issue_valid_b, issue_ready_b, deq_valid_b, deq_ready_b;
  logic [31:0] op, pipe_result, deq_data, deq_data_b;
  logic [3:0]  occupancy;
  logic [1:0]  occupancy_b;
  logic [LAT-1:0][31:0] core_r;

  int vectors = 0;
  int miscompares = 0;
  int acc, got, errs, gaps, drops, next_val;
  logic accept_now;

  always #5 clock = ~clock;

  // Enable-less core model: the operand emerges exactly LAT edges later.
  always_ff @(posedge clock) core_r <= {core_r[LAT-2:0], op};
  assign pipe_result = core_r[LAT-1];

  float_pipe_result_collector #(.WIDTH(32), .LATENCY(LAT), .DEPTH(8)) dut_a (
    .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .pipe_result(pipe_result), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_data(deq_data), .occupancy(occupancy));

  float_pipe_result_collector #(.WIDTH(32), .LATENCY(LAT), .DEPTH(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid_b), .issue_ready(issue_ready_b),
    .pipe_result(pipe_result), .deq_valid(deq_valid_b), .deq_ready(deq_ready_b),
    .deq_data(deq_data_b), .occupancy(occupancy_b));

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; issue_valid = 1'b0; deq_ready = 1'b0; op = 32'h0;
    issue_valid_b = 1'b0; deq_ready_b = 1'b0;
    step(); step();
    check("rst_issue_ready", 64'(issue_ready), 64'd1);
    check("rst_deq_valid", 64'(deq_valid), 64'd0);
    check("rst_deq_data", 64'(deq_data), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_b_occupancy", 64'(occupancy_b), 64'd0);
    reset_n = 1'b1;
    step();

    // Single issue: capture at issue edge + 5, visible the cycle after.
    issue_valid = 1'b1; op = 32'h40490FDB;
    step();
    issue_valid = 1'b0; op = 32'h0;
    check("single_occ_inflight", 64'(occupancy), 64'd1);
    errs = 0;
    for (int i = 1; i < LAT; i++) begin
      step();
      if (deq_valid !== 1'b0) errs++;
    end
    check("single_early_valid", 64'(errs), 64'd0);
    step();
    check("single_deq_valid", 64'(deq_valid), 64'd1);
    check("single_deq_data", 64'(deq_data), 64'h40490FDB);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    check("single_after_deq_valid", 64'(deq_valid), 64'd0);
    check("single_after_deq_data", 64'(deq_data), 64'd0);
    check("single_after_deq_occ", 64'(occupancy), 64'd0);

    // Back-to-back: 100 issues, consumer always ready.
    deq_ready = 1'b1; got = 0; errs = 0; gaps = 0; drops = 0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (deq_valid) begin
        if (deq_data !== 32'(100 + got)) errs++;
        got++;
      end else if (got > 0 && got < 100) begin
        gaps++;
      end
      if (cyc < 100 && issue_ready !== 1'b1) drops++;
      issue_valid = (cyc < 100);
      op = 32'(100 + cyc);
      step();
    end
    issue_valid = 1'b0; deq_ready = 1'b0;
    check("b2b_ready_drops", 64'(drops), 64'd0);
    check("b2b_order_errs", 64'(errs), 64'd0);
    check("b2b_gaps", 64'(gaps), 64'd0);
    check("b2b_count", 64'(got), 64'd100);
    check("b2b_final_occ", 64'(occupancy), 64'd0);

    // Backpressure: exactly DEPTH accepted, then one more per dequeue.
    acc = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      issue_valid = 1'b1;
      op = 32'(200 + acc);
      if (issue_ready) acc++;
      step();
    end
    issue_valid = 1'b0;
    check("bp_accepted", 64'(acc), 64'd8);
    check("bp_issue_ready", 64'(issue_ready), 64'd0);
    check("bp_occupancy", 64'(occupancy), 64'd8);
    step(); step(); step();
    check("bp_head", 64'(deq_data), 64'd200);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    check("bp_credit_back", 64'(issue_ready), 64'd1);
    check("bp_occ_after_deq", 64'(occupancy), 64'd7);
    check("bp_next_head", 64'(deq_data), 64'd201);
    acc = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      issue_valid = 1'b1;
      op = 32'd300;
      if (issue_ready) acc++;
      step();
    end
    issue_valid = 1'b0;
    check("bp_one_more", 64'(acc), 64'd1);
    check("bp_occ_full_again", 64'(occupancy), 64'd8);
    deq_ready = 1'b1; got = 0; errs = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (deq_valid) begin
        if (deq_data !== ((got < 7) ? 32'(201 + got) : 32'd300)) errs++;
        got++;
      end
      step();
    end
    deq_ready = 1'b0;
    check("bp_drain_count", 64'(got), 64'd8);
    check("bp_drain_order", 64'(errs), 64'd0);

    // Simultaneous capture and dequeue with one entry held.
    issue_valid = 1'b1; op = 32'hA1;
    step();
    op = 32'hB2;
    step();
    issue_valid = 1'b0; op = 32'h0;
    step(); step(); step(); step();
    check("sim_pre_head", 64'(deq_data), 64'hA1);
    check("sim_pre_occ", 64'(occupancy), 64'd2);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    check("sim_occ", 64'(occupancy), 64'd1);
    check("sim_valid", 64'(deq_valid), 64'd1);
    check("sim_head", 64'(deq_data), 64'hB2);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    check("sim_empty", 64'(deq_valid), 64'd0);

    // Reset with 3 in flight and 2 queued.
    for (int cyc = 0; cyc < 5; cyc++) begin
      issue_valid = 1'b1;
      op = 32'(32'hC0 + cyc);
      step();
    end
    issue_valid = 1'b0;
    step(); step();
    check("mid_pre_occ", 64'(occupancy), 64'd5);
    check("mid_pre_valid", 64'(deq_valid), 64'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("mid_deq_valid", 64'(deq_valid), 64'd0);
    check("mid_occupancy", 64'(occupancy), 64'd0);
    check("mid_issue_ready", 64'(issue_ready), 64'd1);
    errs = 0;
    for (int cyc = 0; cyc < LAT + 2; cyc++) begin
      step();
      if (deq_valid !== 1'b0 || occupancy !== 4'd0) errs++;
    end
    check("mid_no_stale", 64'(errs), 64'd0);

    // Wrap on the DEPTH=3 instance: values 1..10 in order.
    deq_ready_b = 1'b1; next_val = 1; got = 0; errs = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (deq_valid_b) begin
        if (deq_data_b !== 32'(got + 1)) errs++;
        got++;
      end
      issue_valid_b = (next_val <= 10);
      op = 32'(next_val);
      accept_now = issue_valid_b && issue_ready_b;
      step();
      if (accept_now) next_val++;
    end
    issue_valid_b = 1'b0; deq_ready_b = 1'b0;
    check("wrap_count", 64'(got), 64'd10);
    check("wrap_order", 64'(errs), 64'd0);
    check("wrap_occ", 64'(occupancy_b), 64'd0);
    check("wrap_empty", 64'(deq_valid_b), 64'd0);
    check("wrap_ready", 64'(issue_ready_b), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
